// File: rtl/instr_fetch_if.sv
// Shared address/data sizing for the core and the instruction memory read
// channel used by the fetch stage.
package arv_pkg;
    localparam int XLEN          = 32;
    localparam int PHY_ADDR_SIZE = 32;
endpackage

// Memory read channel: requester drives rd_en/rd_addr, the memory answers
// with rd_valid/rd_data some cycles later, in request order.
interface memory_read_if;
    import arv_pkg::*;

    logic                     rd_en;
    logic [PHY_ADDR_SIZE-1:0] rd_addr;
    logic [XLEN-1:0]          rd_data;
    logic                     rd_valid;

    modport REQ (output rd_en, output rd_addr, input rd_data, input rd_valid);
    modport RSP (input rd_en, input rd_addr, output rd_data, output rd_valid);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single outstanding read, 2-entry in-order
// instruction buffer, redirect flush with late-response drop.
// Optional feature macro: ARV_FETCH_ALIGN_CHECK_EN -- when defined a redirect
// to a non word-aligned target raises a sticky misaligned fault and stops
// fetching; when undefined the low target bits are cleared instead.
module instr_fetch
    import arv_pkg::*;
#(
    parameter logic [PHY_ADDR_SIZE-1:0] RESET_PC = {PHY_ADDR_SIZE{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst_n,
    memory_read_if.REQ               mem,
    input  logic                     redirect,
    input  logic [PHY_ADDR_SIZE-1:0] redirect_pc,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [XLEN-1:0]          inst_data,
    output logic [PHY_ADDR_SIZE-1:0] inst_pc,
    output logic                     misaligned
);

    localparam logic [PHY_ADDR_SIZE-1:0] PC_STEP    = {{(PHY_ADDR_SIZE-3){1'b0}}, 3'b100};
    localparam logic [PHY_ADDR_SIZE-1:0] ALIGN_MASK = {{(PHY_ADDR_SIZE-2){1'b1}}, 2'b00};
    localparam logic [PHY_ADDR_SIZE-1:0] ADDR_ZERO  = {PHY_ADDR_SIZE{1'b0}};
    localparam logic [XLEN-1:0]          DATA_ZERO  = {XLEN{1'b0}};

    // Registered state
    logic [PHY_ADDR_SIZE-1:0] pc_r;
    logic [PHY_ADDR_SIZE-1:0] req_addr_r;
    logic                     out_r;
    logic                     drop_r;
    logic                     misaligned_r;
    logic                     head_r;
    logic [1:0]               count_r;
    logic [XLEN-1:0]          buf_data_r [2];
    logic [PHY_ADDR_SIZE-1:0] buf_pc_r   [2];

    // Next-state and control
    logic [PHY_ADDR_SIZE-1:0] pc_s;
    logic [PHY_ADDR_SIZE-1:0] req_addr_s;
    logic                     out_s;
    logic                     drop_s;
    logic                     misaligned_s;
    logic                     head_s;
    logic [1:0]               count_s;
    logic                     issue_s;
    logic                     rsp_s;
    logic                     push_s;
    logic                     pop_s;
    logic                     tail_s;
    logic [PHY_ADDR_SIZE-1:0] target_s;
    logic                     target_bad_s;

`ifdef ARV_FETCH_ALIGN_CHECK_EN
    assign target_s     = redirect_pc;
    assign target_bad_s = (redirect_pc[1:0] != 2'b00);
`else
    assign target_s     = redirect_pc & ALIGN_MASK;
    assign target_bad_s = 1'b0;
`endif

    // Request issue, response acceptance and buffer push/pop qualification
    always_comb begin
        issue_s = rst_n && !out_r && !redirect && !misaligned_r &&
                  (({1'b0, count_r} + {2'b00, out_r}) < 3'd2);
        rsp_s   = mem.rd_valid && out_r;
        push_s  = rsp_s && !drop_r && !redirect;
        pop_s   = (count_r != 2'd0) && inst_ready && !redirect;
        tail_s  = head_r ^ (count_r == 2'd1);
    end

    // Next-state: redirect flushes and retargets; otherwise issue/accept/pop
    always_comb begin
        pc_s         = pc_r;
        req_addr_s   = req_addr_r;
        out_s        = out_r;
        drop_s       = drop_r;
        misaligned_s = misaligned_r;
        head_s       = head_r;
        count_s      = count_r;
        if (redirect) begin
            pc_s         = target_s;
            head_s       = 1'b0;
            count_s      = 2'd0;
            misaligned_s = misaligned_r | target_bad_s;
            if (rsp_s) begin
                // Coincident response is simply discarded.
                out_s  = 1'b0;
                drop_s = 1'b0;
            end else if (out_r) begin
                // Stale read still in flight: discard whatever comes back.
                drop_s = 1'b1;
            end else begin
                drop_s = drop_r;
            end
        end else begin
            if (issue_s) begin
                out_s      = 1'b1;
                req_addr_s = pc_r;
                pc_s       = pc_r + PC_STEP;
            end else if (rsp_s) begin
                out_s  = 1'b0;
                drop_s = 1'b0;
            end else begin
                out_s = out_r;
            end
            if (pop_s) begin
                head_s = ~head_r;
            end else begin
                head_s = head_r;
            end
            count_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // State and buffer registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            req_addr_r    <= ADDR_ZERO;
            out_r         <= 1'b0;
            drop_r        <= 1'b0;
            misaligned_r  <= 1'b0;
            head_r        <= 1'b0;
            count_r       <= 2'd0;
            buf_data_r[0] <= DATA_ZERO;
            buf_data_r[1] <= DATA_ZERO;
            buf_pc_r[0]   <= ADDR_ZERO;
            buf_pc_r[1]   <= ADDR_ZERO;
        end else begin
            pc_r         <= pc_s;
            req_addr_r   <= req_addr_s;
            out_r        <= out_s;
            drop_r       <= drop_s;
            misaligned_r <= misaligned_s;
            head_r       <= head_s;
            count_r      <= count_s;
            if (push_s) begin
                buf_data_r[tail_s] <= mem.rd_data;
                buf_pc_r[tail_s]   <= req_addr_r;
            end
        end
    end

    // Outputs: request from registered state, instruction from buffer head
    always_comb begin
        mem.rd_en   = issue_s;
        mem.rd_addr = pc_r;
        inst_valid  = rst_n && (count_r != 2'd0);
        misaligned  = misaligned_r;
        if (inst_valid) begin
            inst_data = buf_data_r[head_r];
            inst_pc   = buf_pc_r[head_r];
        end else begin
            inst_data = DATA_ZERO;
            inst_pc   = ADDR_ZERO;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected request addresses and expected
// delivered instructions are queued by the stimulus; a negedge monitor pops
// and compares whenever the DUT issues a read or hands over an instruction.
module tb_instr_fetch;
    import arv_pkg::*;

    typedef logic [PHY_ADDR_SIZE-1:0] addr_t;

    logic            clk;
    logic            rst_n;
    logic            redirect;
    addr_t           redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    addr_t           inst_pc;
    logic            misaligned;

    memory_read_if mem_if ();

    instr_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem         (mem_if),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .misaligned  (misaligned)
    );

    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_rd     = 0;
    int    n_pop    = 0;
    int    lat      = 1;
    int    inject_req = 0;
    int    inject_ack = 0;
    addr_t exp_addr[$];
    addr_t exp_inst[$];
    addr_t mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] mem_word(input addr_t a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic fail_evt(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got 0x%08h expected no event", name, act);
    endtask

    // Monitor: compare every issued read and every delivered instruction
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_if.rd_en) begin
                n_rd++;
                if (exp_addr.size() == 0) fail_evt("rd_addr_unexpected", mem_if.rd_addr);
                else check("rd_addr", mem_if.rd_addr, exp_addr.pop_front());
            end
            if (inst_valid && inst_ready && !redirect) begin
                n_pop++;
                if (exp_inst.size() == 0) fail_evt("inst_unexpected", inst_pc);
                else begin
                    mon_e = exp_inst.pop_front();
                    check("inst_pc", inst_pc, mon_e);
                    check("inst_data", inst_data, mem_word(mon_e));
                end
            end
        end
    end

    // Memory model: fixed latency, one response per request, optional stray response
    logic  m_seen, m_seen_rst, m_pend;
    addr_t m_seen_addr, m_addr;
    int    m_cnt;
    initial begin
        mem_if.rd_valid = 1'b0;
        mem_if.rd_data  = 32'h0;
        m_pend = 1'b0;
        m_cnt  = 0;
        m_addr = 32'h0;
        forever begin
            @(negedge clk);
            m_seen      = mem_if.rd_en && rst_n;
            m_seen_addr = mem_if.rd_addr;
            m_seen_rst  = !rst_n;
            @(posedge clk);
            #1;
            mem_if.rd_valid = 1'b0;
            if (m_seen_rst) begin
                m_pend = 1'b0;
            end else begin
                if (m_seen) begin
                    m_pend = 1'b1;
                    m_cnt  = lat;
                    m_addr = m_seen_addr;
                end
                if (m_pend) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        mem_if.rd_valid = 1'b1;
                        mem_if.rd_data  = mem_word(m_addr);
                        m_pend = 1'b0;
                    end
                end else if (inject_ack != inject_req) begin
                    inject_ack++;
                    mem_if.rd_valid = 1'b1;
                    mem_if.rd_data  = 32'hDEAD_BEEF;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, check reset outputs, release into cycle c0
    task automatic do_reset();
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;
        tick();
        tick();
        check1("rst_rd_en", mem_if.rd_en, 1'b0);
        check1("rst_inst_valid", inst_valid, 1'b0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check1("rst_misaligned", misaligned, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_addr_q_left"}, 32'(exp_addr.size()), 32'd0);
        check({tag, "_inst_q_left"}, 32'(exp_inst.size()), 32'd0);
        exp_addr.delete();
        exp_inst.delete();
    endtask

    initial begin
        automatic int rd0;
        automatic int pop0;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;

        // Sequential fetch from RESET_PC at full throughput
        do_reset();
        lat = 1;
        inst_ready = 1'b1;
        exp_addr = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
        exp_inst = '{32'h100, 32'h104, 32'h108};
        rd0 = n_rd;
        pop0 = n_pop;
        repeat (7) tick();
        check("thru_reads", 32'(n_rd - rd0), 32'd4);
        check("thru_pops", 32'(n_pop - pop0), 32'd3);
        inst_ready = 1'b0;
        repeat (6) tick();
        check_empty("seq");

        // Back-pressure: two reads fill the buffer, head held, then drain
        do_reset();
        lat = 1;
        exp_addr = '{32'h100, 32'h104};
        rd0 = n_rd;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 5) inject_req++;
            if (i >= 3) begin
                check1("hold_valid", inst_valid, 1'b1);
                check("hold_pc", inst_pc, 32'h100);
                check("hold_data", inst_data, mem_word(32'h100));
            end
        end
        check("hold_two_reads", 32'(n_rd - rd0), 32'd2);
        exp_addr.push_back(32'h108);
        exp_addr.push_back(32'h10C);
        exp_inst = '{32'h100, 32'h104};
        inst_ready = 1'b1;
        tick();
        tick();
        inst_ready = 1'b0;
        repeat (6) tick();
        // Redirect with full buffer and ready high: flush wins over pop
        exp_addr.push_back(32'h200);
        exp_addr.push_back(32'h204);
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect   = 1'b0;
        inst_ready = 1'b0;
        check1("flush_valid", inst_valid, 1'b0);
        repeat (5) tick();
        check("flush_head_pc", inst_pc, 32'h200);
        check_empty("hold");

        // Redirect while 0x108 is in flight with 3-cycle memory: response dropped
        do_reset();
        lat = 3;
        inst_ready = 1'b1;
        exp_addr = '{32'h100, 32'h104, 32'h108, 32'h400, 32'h404, 32'h408};
        exp_inst = '{32'h100, 32'h104, 32'h400};
        repeat (9) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        tick();
        redirect = 1'b0;
        check1("drop_valid_after", inst_valid, 1'b0);
        repeat (7) tick();
        inst_ready = 1'b0;
        repeat (12) tick();
        check_empty("drop");

        // Redirect coincident with rd_valid: response discarded, no drop pending
        do_reset();
        lat = 1;
        inst_ready = 1'b1;
        exp_addr = '{32'h100, 32'h400, 32'h404, 32'h408};
        exp_inst = '{32'h400};
        tick();
        #1;
        check1("coinc_rd_valid", mem_if.rd_valid, 1'b1);
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        tick();
        redirect = 1'b0;
        #1;
        check1("coinc_rd_en", mem_if.rd_en, 1'b1);
        check("coinc_rd_addr", mem_if.rd_addr, 32'h400);
        check1("coinc_valid", inst_valid, 1'b0);
        repeat (3) tick();
        inst_ready = 1'b0;
        repeat (6) tick();
        check_empty("coinc");

        // Address wrap at the top of the address space
        do_reset();
        lat = 1;
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        exp_addr = '{32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
        exp_inst = '{32'hFFFF_FFFC, 32'h0};
        tick();
        redirect = 1'b0;
        repeat (5) tick();
        inst_ready = 1'b0;
        repeat (6) tick();
        check_empty("wrap");

        // Misaligned redirect target
        do_reset();
        lat = 1;
        redirect    = 1'b1;
        redirect_pc = 32'h402;
`ifndef ARV_FETCH_ALIGN_CHECK_EN
        exp_addr = '{32'h400, 32'h404};
`endif
        tick();
        redirect = 1'b0;
        repeat (5) tick();
`ifdef ARV_FETCH_ALIGN_CHECK_EN
        check1("misal_flag", misaligned, 1'b1);
        check1("misal_valid", inst_valid, 1'b0);
`else
        check1("misal_flag", misaligned, 1'b0);
        check1("misal_valid", inst_valid, 1'b1);
        check("misal_pc", inst_pc, 32'h400);
`endif
        check_empty("misal");

        // Reset clears the sticky fault and fetch restarts at RESET_PC
        do_reset();
        exp_addr = '{32'h100};
        tick();
        tick();
        check_empty("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
